man_demod: RTL and testbench

MAN_DEMOD -- requirements
Module: man_demod

---
 rtl/man_demod.sv | 131 +++++++++++++
 tb/tb_man_demod.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/man_demod.sv
// Manchester line decoder: syncs in_data, locks on a start bit, emits bits/bytes.
// Ports: clk, rst_n (sync, low), in_enable, in_data -> out_bit/_valid, out_byte/_valid, out_err, out_busy.
module man_demod #(
  parameter int HALF_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_enable,
  input  logic       in_data,
  output logic       out_bit,
  output logic       out_bit_valid,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  output logic       out_err,
  output logic       out_busy
);

  localparam int CW = $clog2(3*HALF_BIT+1);
  localparam logic [CW-1:0] WIN_LO = CW'(3*HALF_BIT/2);
  localparam logic [CW-1:0] WIN_HI = CW'(5*HALF_BIT/2);
  localparam logic [CW-1:0] TMO    = CW'(5*HALF_BIT/2+1);
  localparam logic [CW-1:0] SAT    = CW'(3*HALF_BIT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state, nxt_state;

  logic sync_a, sync_b, dly;
  logic tog_q, lvl_q;

  logic [CW-1:0] cnt, nxt_cnt;
  logic [2:0]    bcnt, nxt_bcnt;
  logic [7:0]    shift, nxt_shift;
  logic          nxt_bit, nxt_bit_valid;
  logic [7:0]    nxt_byte;
  logic          nxt_byte_valid, nxt_err;

  // sync_b vs dly marks a line change; tog_q/lvl_q register it
  // so the decoder sees a clean, aligned edge and level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      dly    <= 1'b0;
      tog_q  <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      sync_a <= in_data;
      sync_b <= sync_a;
      dly    <= sync_b;
      tog_q  <= sync_b ^ dly;
      lvl_q  <= sync_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bcnt           <= '0;
      shift          <= '0;
      out_bit        <= 1'b0;
      out_bit_valid  <= 1'b0;
      out_byte       <= '0;
      out_byte_valid <= 1'b0;
      out_err        <= 1'b0;
    end else begin
      state          <= nxt_state;
      cnt            <= nxt_cnt;
      bcnt           <= nxt_bcnt;
      shift          <= nxt_shift;
      out_bit        <= nxt_bit;
      out_bit_valid  <= nxt_bit_valid;
      out_byte       <= nxt_byte;
      out_byte_valid <= nxt_byte_valid;
      out_err        <= nxt_err;
    end
  end

  always_comb begin
    nxt_state      = state;
    nxt_cnt        = cnt;
    nxt_bcnt       = bcnt;
    nxt_shift      = shift;
    nxt_bit        = out_bit;
    nxt_bit_valid  = 1'b0;
    nxt_byte       = out_byte;
    nxt_byte_valid = 1'b0;
    nxt_err        = 1'b0;
    if (!in_enable) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_bcnt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          // first rising edge is the start bit's mid-bit
          if (tog_q && lvl_q) begin
            nxt_state = LOCKED;
            nxt_cnt   = '0;
            nxt_bcnt  = '0;
          end
        end
        LOCKED: begin
          if (tog_q && cnt >= WIN_LO && cnt <= WIN_HI) begin
            nxt_cnt       = '0;
            nxt_bit       = lvl_q;
            nxt_bit_valid = 1'b1;
            nxt_shift     = {shift[6:0], lvl_q};
            nxt_bcnt      = bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              nxt_byte       = {shift[6:0], lvl_q};
              nxt_byte_valid = 1'b1;
            end
          end else if (cnt >= TMO) begin
            nxt_err   = 1'b1;
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_bcnt  = '0;
          end else if (cnt < SAT) begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  assign out_busy = (state != IDLE);

endmodule

// File: tb/tb_man_demod.sv
// Directed bench for man_demod: vector table of frames plus
// hand-built timeout, jitter, disable and reset sequences.
module tb_man_demod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_enable;
  logic       in_data;
  logic       out_bit;
  logic       out_bit_valid;
  logic [7:0] out_byte;
  logic       out_byte_valid;
  logic       out_err;
  logic       out_busy;

  man_demod #(.HALF_BIT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_enable(in_enable),
    .in_data(in_data),
    .out_bit(out_bit),
    .out_bit_valid(out_bit_valid),
    .out_byte(out_byte),
    .out_byte_valid(out_byte_valid),
    .out_err(out_err),
    .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int         bit_cyc[$];
  logic       bit_val[$];
  int         byte_cyc[$];
  logic [7:0] byte_val[$];
  int         err_cyc[$];

  always @(negedge clk) begin
    if (out_bit_valid) begin
      bit_cyc.push_back(cyc);
      bit_val.push_back(out_bit);
    end
    if (out_byte_valid) begin
      byte_cyc.push_back(cyc);
      byte_val.push_back(out_byte);
    end
    if (out_err) err_cyc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_err = 0;
  int mid_cyc[9];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    bit_cyc.delete();
    bit_val.delete();
    byte_cyc.delete();
    byte_val.delete();
    err_cyc.delete();
  endtask

  task automatic hold(input logic v, input int n);
    in_data = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, output int mc);
    hold(~b, 4);
    mc = cyc;
    hold(b, 4);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bit(1'b1, mid_cyc[0]);
    for (int i = 0; i < 8; i++)
      send_bit(b[7-i], mid_cyc[i+1]);
  endtask

  task automatic end_frame();
    in_enable = 1'b0;
    hold(1'b0, 8);
    in_enable = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_bit"}, int'(out_bit), 0);
    chk({tag, " out_bit_valid"}, int'(out_bit_valid), 0);
    chk({tag, " out_byte"}, int'(out_byte), 0);
    chk({tag, " out_byte_valid"}, int'(out_byte_valid), 0);
    chk({tag, " out_err"}, int'(out_err), 0);
    chk({tag, " out_busy"}, int'(out_busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] e;
    e = v.exp;
    clear_mon();
    send_frame(v.data);
    hold(in_data, 4);
    chk({tag, " bit count"}, bit_val.size(), 8);
    if (bit_val.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s bit%0d", tag, i), int'(bit_val[i]), int'(e[7-i]));
        chk($sformatf("%s bit%0d cyc", tag, i), bit_cyc[i], mid_cyc[i+1] + 4);
      end
    end
    chk({tag, " byte count"}, byte_val.size(), 1);
    if (byte_val.size() == 1) begin
      chk({tag, " byte"}, int'(byte_val[0]), int'(e));
      chk({tag, " byte cyc"}, byte_cyc[0], mid_cyc[8] + 4);
    end
    chk({tag, " err count"}, err_cyc.size(), 0);
    end_frame();
    chk({tag, " byte hold"}, int'(out_byte), int'(e));
  endtask

  vec_t vecs[4];
  int k, k1, k2;

  initial begin
    vecs[0] = '{data: 8'hA5, exp: 8'hA5};
    vecs[1] = '{data: 8'h00, exp: 8'h00};
    vecs[2] = '{data: 8'h81, exp: 8'h81};
    vecs[3] = '{data: 8'h6E, exp: 8'h6E};

    rst_n = 1'b0;
    in_enable = 1'b0;
    in_data = 1'b0;
    hold(1'b0, 3);
    chk_zero("reset");
    rst_n = 1'b1;
    in_enable = 1'b1;
    hold(1'b0, 8);

    foreach (vecs[i])
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // lock, then line stuck high: timeout at cnt 11
    clear_mon();
    hold(1'b0, 4);
    k = cyc;
    hold(1'b1, 6);
    chk("timeout busy", int'(out_busy), 1);
    hold(1'b1, 14);
    chk("timeout err count", err_cyc.size(), 1);
    if (err_cyc.size() == 1)
      chk("timeout err cyc", err_cyc[0], k + 16);
    chk("timeout busy drop", int'(out_busy), 0);
    chk("timeout bits", bit_val.size(), 0);
    chk("timeout bytes", byte_val.size(), 0);
    end_frame();

    // jitter: accept at cnt 6 and 10, ignore cnt 5 then timeout
    clear_mon();
    hold(1'b0, 4);
    k = cyc;
    hold(1'b1, 4);
    hold(1'b0, 3);
    k1 = cyc;
    hold(1'b1, 11);
    k2 = cyc;
    hold(1'b0, 6);
    hold(1'b1, 14);
    chk("jit bit count", bit_val.size(), 2);
    if (bit_val.size() == 2) begin
      chk("jit bit0", int'(bit_val[0]), 1);
      chk("jit bit0 cyc", bit_cyc[0], k1 + 4);
      chk("jit bit1", int'(bit_val[1]), 0);
      chk("jit bit1 cyc", bit_cyc[1], k2 + 4);
    end
    chk("jit err count", err_cyc.size(), 1);
    if (err_cyc.size() == 1)
      chk("jit err cyc", err_cyc[0], k2 + 16);
    chk("jit bytes", byte_val.size(), 0);
    end_frame();

    // disable after 3 bits, then a clean 0x3C frame
    clear_mon();
    send_bit(1'b1, k);
    send_bit(1'b1, k);
    send_bit(1'b0, k);
    send_bit(1'b1, k);
    hold(in_data, 2);
    chk("dis partial bits", bit_val.size(), 3);
    clear_mon();
    in_enable = 1'b0;
    hold(1'b0, 8);
    chk("dis bits", bit_val.size(), 0);
    chk("dis errs", err_cyc.size(), 0);
    chk("dis busy", int'(out_busy), 0);
    in_enable = 1'b1;
    run_vec('{data: 8'h3C, exp: 8'h3C}, "after_dis");

    // reset after 5 bits, then 0xFF
    clear_mon();
    send_bit(1'b1, k);
    send_bit(1'b0, k);
    send_bit(1'b1, k);
    send_bit(1'b1, k);
    send_bit(1'b0, k);
    send_bit(1'b1, k);
    hold(in_data, 2);
    clear_mon();
    rst_n = 1'b0;
    hold(1'b0, 3);
    chk_zero("midrst");
    rst_n = 1'b1;
    hold(1'b0, 6);
    chk("midrst bits", bit_val.size(), 0);
    chk("midrst bytes", byte_val.size(), 0);
    chk("midrst errs", err_cyc.size(), 0);
    run_vec('{data: 8'hFF, exp: 8'hFF}, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
